// File: rtl/fsm_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsm_mon_pkg
// Brief    : Shared types and constants for the FSM state monitor: monitor
//            state encoding, first-fault cause codes and dwell counter width.
// Revision : 1.0 - initial release
// ============================================================================
package fsm_mon_pkg;

  // Monitor's own state: IDLE re-learns the reference state, RUN checks,
  // FAULT keeps checking after at least one sticky flag has been raised.
  typedef enum logic [1:0] {
    MON_IDLE  = 2'd0,
    MON_RUN   = 2'd1,
    MON_FAULT = 2'd2
  } mon_state_e;

  // First-fault cause reported on err_code.
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ENC   = 2'd1;
  localparam logic [1:0] ERR_TRANS = 2'd2;
  localparam logic [1:0] ERR_STUCK = 2'd3;

  // Dwell counter width; wide enough for the largest supported timeout (255).
  localparam int unsigned DWELL_W = 8;

endpackage : fsm_mon_pkg
`default_nettype wire

// File: rtl/fsm_dwell_counter.sv
`default_nettype none
// ============================================================================
// Module   : fsm_dwell_counter
// Brief    : Saturating count of consecutive repeats of the observed state.
//            at_limit flags the increment that lands on (or stays at) TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_dwell_counter
  import fsm_mon_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [DWELL_W-1:0] c_limit = DWELL_W'(TIMEOUT);
  localparam logic [DWELL_W-1:0] c_pre   = DWELL_W'(TIMEOUT - 1);

  logic [DWELL_W-1:0] count_q;
  logic [DWELL_W-1:0] count_d;

  // Clear wins over increment; counting stops once the limit is reached.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != c_limit)) begin
      count_d = count_q + DWELL_W'(1);
    end
  end

  // Independent of clr so a timeout in the same cycle as a clear still counts.
  assign at_limit = inc && (count_q >= c_pre);

  // Count register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : fsm_dwell_counter
`default_nettype wire

// File: rtl/fsm_state_monitor.sv
`default_nettype none
// ============================================================================
// Module   : fsm_state_monitor
// Brief    : Watches a one-hot FSM state vector and raises sticky flags for
//            non-one-hot encodings, illegal transitions and dwell timeouts,
//            records visited states and reports the first fault cause.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_state_monitor
  import fsm_mon_pkg::*;
#(
  parameter int                  N_STATES   = 4,
  parameter                      LEGAL_MASK = 16'h1152,
  parameter logic [N_STATES-1:0] DWELL_OK   = 4'b0001,
  parameter int                  TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [N_STATES-1:0] state,
  input  logic                clear,
  output logic                enc_err,
  output logic                trans_err,
  output logic                stuck,
  output logic [N_STATES-1:0] visited,
  output logic                err_pulse,
  output logic [1:0]          err_code
);

  // Elaboration-time parameter sanity checks.
  if ($bits(LEGAL_MASK) != N_STATES * N_STATES) begin : g_bad_mask
    $error("fsm_state_monitor: LEGAL_MASK must be N_STATES*N_STATES bits wide");
  end
  if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("fsm_state_monitor: TIMEOUT must be in 2..255");
  end

  localparam logic [N_STATES*N_STATES-1:0] c_legal_mask = LEGAL_MASK;

  mon_state_e          mon_q, mon_d;
  logic [N_STATES-1:0] prev_q, prev_d;
  logic [N_STATES-1:0] visited_q, visited_d;
  logic                enc_err_q, enc_err_d;
  logic                trans_err_q, trans_err_d;
  logic                stuck_q, stuck_d;
  logic                err_pulse_q, err_pulse_d;
  logic [1:0]          err_code_q, err_code_d;

  logic                w_checking;
  logic                w_onehot;
  logic                w_prev_valid;
  logic                w_same;
  logic                w_legal_move;
  logic [N_STATES-1:0] w_row_hit;
  logic                w_enc_hit;
  logic                w_trans_hit;
  logic                w_stuck_hit;
  logic                w_any_hit;
  logic                w_dwell_inc;
  logic                w_dwell_clr;
  logic                w_at_limit;
  logic [1:0]          w_new_code;
  logic [1:0]          w_code_base;

  // Both vectors are one-hot when checked, so row prev ANDed with column
  // state picks exactly the mask bit for prev -> state.
  for (genvar gi = 0; gi < N_STATES; gi++) begin : g_row
    assign w_row_hit[gi] = prev_q[gi] & (|(state & c_legal_mask[gi*N_STATES +: N_STATES]));
  end

  assign w_checking   = (mon_q != MON_IDLE);
  assign w_onehot     = (state != '0) && ((state & (state - N_STATES'(1))) == '0);
  assign w_prev_valid = (prev_q != '0) && ((prev_q & (prev_q - N_STATES'(1))) == '0);
  assign w_same       = (state == prev_q);
  assign w_legal_move = |w_row_hit;

  // A bad encoding is not compared against prev; a change of one-hot state
  // is checked against the mask (self-loops never reach this path).
  assign w_enc_hit   = w_checking & ~w_onehot;
  assign w_trans_hit = w_checking & w_onehot & w_prev_valid & ~w_same & ~w_legal_move;

  // Dwell counts repeats of the current state; any change or glitch restarts it.
  assign w_dwell_inc = w_checking & w_onehot & w_same;
  assign w_dwell_clr = clear | ~w_dwell_inc;
  assign w_stuck_hit = w_at_limit & ((state & DWELL_OK) == '0);
  assign w_any_hit   = w_enc_hit | w_trans_hit | w_stuck_hit;

  fsm_dwell_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_dwell (
    .clk      (clk),
    .resetn   (resetn),
    .inc      (w_dwell_inc),
    .clr      (w_dwell_clr),
    .at_limit (w_at_limit)
  );

  // First-cause priority encoder: enc beats trans beats stuck.
  always_comb begin
    w_new_code = ERR_NONE;
    if (w_enc_hit) begin
      w_new_code = ERR_ENC;
    end else if (w_trans_hit) begin
      w_new_code = ERR_TRANS;
    end else if (w_stuck_hit) begin
      w_new_code = ERR_STUCK;
    end
  end

  // Next-state logic for the monitor FSM, reference state and sticky records.
  always_comb begin
    mon_d  = mon_q;
    prev_d = prev_q;
    unique case (mon_q)
      MON_IDLE: begin
        prev_d = state;
        mon_d  = MON_RUN;
      end
      MON_RUN: begin
        if (w_onehot) prev_d = state;
        if (w_any_hit) mon_d = MON_FAULT;
      end
      MON_FAULT: begin
        if (w_onehot) prev_d = state;
      end
      default: begin
        mon_d = MON_IDLE;
      end
    endcase
    // A fault seen in the clear cycle survives the clear.
    if (clear) begin
      mon_d = w_any_hit ? MON_FAULT : MON_IDLE;
    end

    enc_err_d   = (enc_err_q   & ~clear) | w_enc_hit;
    trans_err_d = (trans_err_q & ~clear) | w_trans_hit;
    stuck_d     = (stuck_q     & ~clear) | w_stuck_hit;
    visited_d   = (clear ? '0 : visited_q) | (w_onehot ? state : '0);

    w_code_base = clear ? ERR_NONE : err_code_q;
    err_code_d  = (w_code_base == ERR_NONE) ? w_new_code : w_code_base;

    err_pulse_d = (enc_err_d & ~enc_err_q) | (trans_err_d & ~trans_err_q) |
                  (stuck_d & ~stuck_q);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mon_q       <= MON_IDLE;
      prev_q      <= '0;
      visited_q   <= '0;
      enc_err_q   <= 1'b0;
      trans_err_q <= 1'b0;
      stuck_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      mon_q       <= mon_d;
      prev_q      <= prev_d;
      visited_q   <= visited_d;
      enc_err_q   <= enc_err_d;
      trans_err_q <= trans_err_d;
      stuck_q     <= stuck_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

  assign enc_err   = enc_err_q;
  assign trans_err = trans_err_q;
  assign stuck     = stuck_q;
  assign visited   = visited_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;

endmodule : fsm_state_monitor
`default_nettype wire

// File: tb/tb_fsm_state_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_state_monitor
// Brief    : Self-checking bench for fsm_state_monitor (default parameters).
//            Output bundle order: {enc_err, trans_err, stuck, err_pulse,
//            visited[3:0], err_code[1:0]}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_state_monitor;
  import fsm_mon_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] state;
  logic       clear;
  logic       enc_err;
  logic       trans_err;
  logic       stuck;
  logic [3:0] visited;
  logic       err_pulse;
  logic [1:0] err_code;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  st;
    logic        clr;
    logic [11:0] exp;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[17];

  fsm_state_monitor dut (
    .clk       (clk),
    .resetn    (resetn),
    .state     (state),
    .clear     (clear),
    .enc_err   (enc_err),
    .trans_err (trans_err),
    .stuck     (stuck),
    .visited   (visited),
    .err_pulse (err_pulse),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pk(input logic e, input logic t, input logic s,
                                     input logic p, input logic [3:0] v,
                                     input logic [1:0] c);
    return {e, t, s, p, v, c};
  endfunction

  function automatic logic [11:0] outs();
    return {enc_err, trans_err, stuck, err_pulse, visited, err_code};
  endfunction

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %03h expected %03h", name, got, exp);
    end
  endtask

  // Drive one sample, queue its expectation, compare just after the edge.
  task automatic apply(input logic [3:0] st, input logic clr, input logic [11:0] exp,
                       input string name);
    vec_t v;
    state = st;
    clear = clr;
    v.st  = st;
    v.clr = clr;
    v.exp = exp;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      v = sb.pop_front();
      check(name, outs(), v.exp);
    end
  endtask

  initial begin
    // Legal loop, illegal 0->2, clear, enc glitch, later trans in FAULT, clear.
    tbl[0]  = '{4'b0001, 1'b0, pk(0, 0, 0, 0, 4'b0001, 2'd0)};
    tbl[1]  = '{4'b0010, 1'b0, pk(0, 0, 0, 0, 4'b0011, 2'd0)};
    tbl[2]  = '{4'b0100, 1'b0, pk(0, 0, 0, 0, 4'b0111, 2'd0)};
    tbl[3]  = '{4'b0001, 1'b0, pk(0, 0, 0, 0, 4'b0111, 2'd0)};
    tbl[4]  = '{4'b0010, 1'b0, pk(0, 0, 0, 0, 4'b0111, 2'd0)};
    tbl[5]  = '{4'b0100, 1'b0, pk(0, 0, 0, 0, 4'b0111, 2'd0)};
    tbl[6]  = '{4'b0001, 1'b0, pk(0, 0, 0, 0, 4'b0111, 2'd0)};
    tbl[7]  = '{4'b0100, 1'b0, pk(0, 1, 0, 1, 4'b0111, 2'd2)};
    tbl[8]  = '{4'b0100, 1'b0, pk(0, 1, 0, 0, 4'b0111, 2'd2)};
    tbl[9]  = '{4'b0100, 1'b1, pk(0, 0, 0, 0, 4'b0100, 2'd0)};
    tbl[10] = '{4'b0100, 1'b0, pk(0, 0, 0, 0, 4'b0100, 2'd0)};
    tbl[11] = '{4'b0001, 1'b0, pk(0, 0, 0, 0, 4'b0101, 2'd0)};
    tbl[12] = '{4'b0011, 1'b0, pk(1, 0, 0, 1, 4'b0101, 2'd1)};
    tbl[13] = '{4'b0001, 1'b0, pk(1, 0, 0, 0, 4'b0101, 2'd1)};
    tbl[14] = '{4'b0010, 1'b0, pk(1, 0, 0, 0, 4'b0111, 2'd1)};
    tbl[15] = '{4'b1000, 1'b0, pk(1, 1, 0, 1, 4'b1111, 2'd1)};
    tbl[16] = '{4'b0001, 1'b1, pk(0, 0, 0, 0, 4'b0001, 2'd0)};

    resetn = 1'b0;
    state  = 4'b0000;
    clear  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), 12'h000);
    resetn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].st, tbl[i].clr, tbl[i].exp, $sformatf("tbl[%0d]", i));
    end
    check("mon_idle_after_clear", {10'd0, 2'(dut.mon_q)}, {10'd0, MON_IDLE});

    // Dwell timeout: after entering 0010, the 16th repeat sets stuck.
    apply(4'b0001, 1'b0, pk(0, 0, 0, 0, 4'b0001, 2'd0), "stuck_idle");
    apply(4'b0010, 1'b0, pk(0, 0, 0, 0, 4'b0011, 2'd0), "stuck_enter");
    for (int k = 1; k <= 17; k++) begin
      apply(4'b0010, 1'b0,
            pk(0, 0, k >= 16, k == 16, 4'b0011, (k >= 16) ? 2'd3 : 2'd0),
            $sformatf("stuck_hold[%0d]", k));
    end

    // A DWELL_OK state may sit far beyond the timeout.
    apply(4'b0001, 1'b1, pk(0, 0, 0, 0, 4'b0001, 2'd0), "dwell_ok_clear");
    apply(4'b0001, 1'b0, pk(0, 0, 0, 0, 4'b0001, 2'd0), "dwell_ok_idle");
    for (int k = 1; k <= 100; k++) begin
      apply(4'b0001, 1'b0, pk(0, 0, 0, 0, 4'b0001, 2'd0), $sformatf("dwell_ok[%0d]", k));
    end

    // Illegal 1->3 in the same cycle as clear: the fault wins.
    apply(4'b0010, 1'b0, pk(0, 0, 0, 0, 4'b0011, 2'd0), "clr_race_pre");
    apply(4'b1000, 1'b1, pk(0, 1, 0, 1, 4'b1000, 2'd2), "clr_race");
    check("mon_fault_after_race", {10'd0, 2'(dut.mon_q)}, {10'd0, MON_FAULT});
    apply(4'b1000, 1'b0, pk(0, 1, 0, 0, 4'b1000, 2'd2), "clr_race_hold");

    // Asynchronous reset mid-fault, then no check against old history.
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset", outs(), 12'h000);
    state = 4'b0100;
    @(negedge clk);
    resetn = 1'b1;
    apply(4'b0100, 1'b0, pk(0, 0, 0, 0, 4'b0100, 2'd0), "post_reset_0");
    apply(4'b0100, 1'b0, pk(0, 0, 0, 0, 4'b0100, 2'd0), "post_reset_1");
    apply(4'b0001, 1'b0, pk(0, 0, 0, 0, 4'b0101, 2'd0), "post_reset_2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fsm_state_monitor
`default_nettype wire
